// File: rtl/fifo_hs_pkg.sv
// Shared core package: element type and sizing defaults used by fifo_hs and its users.
package fifo_hs_pkg;

    typedef logic [8:0] core_data_t;

    localparam int FIFO_HS_DEFAULT_DEPTH = 4;

endpackage

// File: rtl/fifo_hs_modn_counter.sv
// modn_counter: wrapping 0..N-1 counter with synchronous clear (priority) and enable.
module modn_counter #(
    parameter int  N = 4,
    localparam int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o
);

    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/fifo_hs.sv
// fifo_hs: valid/ready FIFO of DEPTH entries (any DEPTH >= 2) with flush and occupancy count.
// Optional zero-latency pass-through when empty is enabled by defining FIFO_HS_BYPASS_EN.
module fifo_hs
    import fifo_hs_pkg::*;
#(
    parameter type DATA_T = core_data_t,
    parameter int  DEPTH  = FIFO_HS_DEFAULT_DEPTH,
    localparam int CW     = $clog2(DEPTH + 1),
    localparam int PW     = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          flush_i,
    input  logic          valid_i,
    output logic          ready_o,
    input  DATA_T         data_i,
    output logic          valid_o,
    input  logic          ready_i,
    output DATA_T         data_o,
    output logic [CW-1:0] count_o
);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    DATA_T         mem_q [DEPTH];
    DATA_T         mem_d [DEPTH];
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] head, tail;
    logic          push, pop, pass;

    // ready_o depends on registered occupancy only
    always_comb begin
        ready_o = (count_q < DEPTH_C);
`ifdef FIFO_HS_BYPASS_EN
        pass    = (count_q == '0) && valid_i && ready_i && !flush_i;
`else
        pass    = 1'b0;
`endif
        push    = valid_i && ready_o && !pass && !flush_i;
        pop     = (count_q != '0) && ready_i && !flush_i;
    end

    always_comb begin
`ifdef FIFO_HS_BYPASS_EN
        if (count_q == '0) begin
            valid_o = valid_i && !flush_i;
            data_o  = data_i;
        end else begin
            valid_o = 1'b1;
            data_o  = mem_q[head];
        end
`else
        valid_o = (count_q != '0);
        data_o  = mem_q[head];
`endif
    end

    always_comb begin
        count_d = count_q;
        if (flush_i) begin
            count_d = '0;
        end else if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    // flush only rewinds pointers; stored words are left in place
    always_comb begin
        mem_d = mem_q;
        if (push) begin
            mem_d[tail] = data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            count_q <= '0;
            mem_q   <= '{default: '0};
        end else begin
            count_q <= count_d;
            mem_q   <= mem_d;
        end
    end

    modn_counter #(.N(DEPTH)) u_head (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .clr_i   (flush_i),
        .en_i    (pop),
        .cnt_o   (head)
    );

    modn_counter #(.N(DEPTH)) u_tail (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .clr_i   (flush_i),
        .en_i    (push),
        .cnt_o   (tail)
    );

    assign count_o = count_q;

`ifndef SYNTHESIS
    a_count_bound : assert property (@(posedge clk_i) disable iff (!rst_n_i)
        count_q <= DEPTH_C);
    a_no_push_full : assert property (@(posedge clk_i) disable iff (!rst_n_i)
        push |-> (count_q != DEPTH_C));
    a_no_pop_empty : assert property (@(posedge clk_i) disable iff (!rst_n_i)
        pop |-> (count_q != '0));
`endif

endmodule

// File: tb/tb_fifo_hs.sv
// Scoreboard bench for fifo_hs (DEPTH=4, 8-bit data); honours FIFO_HS_BYPASS_EN when defined.
module tb_fifo_hs;

    localparam int DEPTH = 4;
`ifdef FIFO_HS_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic       clk_i = 1'b0;
    logic       rst_n_i = 1'b0;
    logic       flush_i = 1'b0;
    logic       valid_i = 1'b0;
    logic       ready_o;
    logic [7:0] data_i = '0;
    logic       valid_o;
    logic       ready_i = 1'b0;
    logic [7:0] data_o;
    logic [2:0] count_o;

    fifo_hs #(.DATA_T(logic [7:0]), .DEPTH(DEPTH)) dut (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .flush_i (flush_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .data_i  (data_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .data_o  (data_o),
        .count_o (count_o)
    );

    always #5 clk_i = ~clk_i;

    int         pass_cnt = 0;
    int         total_cnt = 0;
    logic [7:0] exp_q[$];
    logic [7:0] out_log[$];
    int         cur_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Reference model: an abstract queue with occupancy; decides acceptance from its own state.
    task automatic step(input bit v, input logic [7:0] d, input bit r, input bit f);
        bit thru, acc, take;
        int nxt;
        valid_i = v; data_i = d; ready_i = r; flush_i = f;
        thru = BYP && (cur_cnt == 0) && v && r && !f;
        acc  = v && (cur_cnt < DEPTH) && !f;
        take = (cur_cnt != 0) && r && !f;
        if (f) begin
            exp_q.delete();
            nxt = 0;
        end else begin
            if (acc) exp_q.push_back(d);
            nxt = cur_cnt + ((acc && !thru) ? 1 : 0) - (take ? 1 : 0);
        end
        @(posedge clk_i);
        #1;
        cur_cnt = nxt;
    endtask

    task automatic check_log(input string name, input logic [7:0] want[$]);
        chk({name, "_len"}, out_log.size(), want.size());
        for (int i = 0; i < want.size() && i < out_log.size(); i++)
            chk($sformatf("%s_%0d", name, i), out_log[i], want[i]);
    endtask

    // Monitor: checks status against the model every cycle and pops the scoreboard on each DUT pop.
    always @(negedge clk_i) begin
        if (rst_n_i) begin
            logic exp_vld;
            exp_vld = (cur_cnt != 0) || (BYP && cur_cnt == 0 && valid_i && !flush_i);
            chk("count_o", count_o, cur_cnt);
            chk("ready_o", ready_o, cur_cnt < DEPTH);
            chk("valid_o", valid_o, exp_vld);
            if (valid_o && ready_i && !flush_i) begin
                if (exp_q.size() == 0) begin
                    chk("pop_on_empty_model", 1, 0);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    chk("data_o", data_o, e);
                    out_log.push_back(data_o);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] want[$];
        // reset state, applied asynchronously before any clock edge
        #3;
        chk("rst_count", count_o, 0);
        chk("rst_ready", ready_o, 1);
        chk("rst_valid", valid_o, 0);
        chk("rst_data", data_o, 0);
        @(posedge clk_i); #1;
        rst_n_i = 1'b1;
        @(posedge clk_i); #1;

        // fill
        step(1, 8'h11, 0, 0); chk("fill_cnt1", count_o, 1);
        step(1, 8'h22, 0, 0); chk("fill_cnt2", count_o, 2);
        step(1, 8'h33, 0, 0); chk("fill_cnt3", count_o, 3);
        step(1, 8'h44, 0, 0); chk("fill_cnt4", count_o, 4);
        chk("fill_ready_full", ready_o, 0);
        step(1, 8'h55, 0, 0); chk("fill_5th_rejected", count_o, 4);

        // drain
        out_log.delete();
        repeat (4) step(0, 8'h00, 1, 0);
        chk("drain_valid", valid_o, 0);
        chk("drain_count", count_o, 0);
        want = '{8'h11, 8'h22, 8'h33, 8'h44};
        check_log("drain_order", want);

        // simultaneous push and pop at count 2
        step(1, 8'h01, 0, 0);
        step(1, 8'h02, 0, 0);
        out_log.delete();
        step(1, 8'hAA, 1, 0);
        chk("simul_count", count_o, 2);
        repeat (3) step(0, 8'h00, 1, 0);
        want = '{8'h01, 8'h02, 8'hAA};
        check_log("simul_order", want);

        // wrap
        out_log.delete();
        for (int i = 0; i < 10; i++) step(1, 8'(i), 1, 0);
        repeat (2) step(0, 8'h00, 1, 0);
        want.delete();
        for (int i = 0; i < 10; i++) want.push_back(8'(i));
        check_log("wrap_order", want);

        // flush with a coincident push
        step(1, 8'hC1, 0, 0);
        step(1, 8'hC2, 0, 0);
        step(1, 8'hC3, 0, 0);
        chk("flush_pre_count", count_o, 3);
        step(1, 8'h77, 0, 1);
        valid_i = 0; flush_i = 0; #1;
        chk("flush_count", count_o, 0);
        chk("flush_valid", valid_o, 0);
        out_log.delete();
        repeat (2) step(0, 8'h00, 1, 0);
        chk("flush_discarded", out_log.size(), 0);

        // bypass / latency-1 behaviour from empty
        out_log.delete();
        valid_i = 1; data_i = 8'h5A; ready_i = 1; #1;
        chk("byp_same_valid", valid_o, BYP);
        if (BYP) chk("byp_same_data", data_o, 8'h5A);
        chk("byp_same_count", count_o, 0);
        step(1, 8'h5A, 1, 0);
        valid_i = 0; ready_i = 0; #1;
        chk("byp_next_valid", valid_o, !BYP);
        chk("byp_next_count", count_o, BYP ? 0 : 1);
        if (!BYP) chk("byp_next_data", data_o, 8'h5A);
        repeat (2) step(0, 8'h00, 1, 0);
        want = '{8'h5A};
        check_log("byp_out", want);

        // randomized traffic
        for (int i = 0; i < 400; i++)
            step(($urandom % 4) != 0, 8'($urandom), ($urandom % 3) != 0, ($urandom % 40) == 0);

        // reset asserted mid-transfer
        step(1, 8'hE1, 0, 0);
        step(1, 8'hE2, 0, 0);
        rst_n_i = 1'b0; #1;
        chk("midrst_count", count_o, 0);
        chk("midrst_ready", ready_o, 1);
        chk("midrst_valid", valid_o, 0);
        chk("midrst_data", data_o, 0);
        exp_q.delete();
        cur_cnt = 0;
        valid_i = 0; ready_i = 0; flush_i = 0;
        @(posedge clk_i); #1;
        rst_n_i = 1'b1;
        @(posedge clk_i); #1;
        out_log.delete();
        repeat (3) step(0, 8'h00, 1, 0);
        chk("midrst_nothing_left", out_log.size(), 0);
        step(1, 8'h3C, 0, 0);
        step(0, 8'h00, 1, 0);
        want = '{8'h3C};
        check_log("midrst_after", want);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/fifo_hs.md
FIFO_HS -- requirements
Module: fifo_hs

Interface
REQ-001 The block SHALL have parameter DATA_T, default logic[8:0], meaning the stored element type.
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning the number of entries (integer, DEPTH >= 2, not necessarily a power of two).
REQ-003 The block SHALL have port clk_i  input  1  clock; reset rst_n_i, asynchronous, active-low; clock clk_i.
REQ-004 The block SHALL have port rst_n_i  input  1  asynchronous active-low reset.
REQ-005 The block SHALL have port flush_i  input  1  synchronous clear of all contents.
REQ-006 The block SHALL have port valid_i  input  1  upstream data valid.
REQ-007 The block SHALL have port ready_o  output  1  FIFO can accept an element.
REQ-008 The block SHALL have port data_i  input  DATA_T  upstream data.
REQ-009 The block SHALL have port valid_o  output  1  head element valid.
REQ-010 The block SHALL have port ready_i  input  1  downstream accepts head.
REQ-011 The block SHALL have port data_o  output  DATA_T  head element.
REQ-012 The block SHALL have port count_o  output  $clog2(DEPTH+1)  current occupancy.

Function
REQ-013 Push SHALL occur when valid_i && ready_o; pop SHALL occur when valid_o && ready_i; both are evaluated on the same rising edge.
REQ-014 ready_o SHALL equal (count_o < DEPTH), registered-state only, with no combinational path from ready_i or valid_i.
REQ-015 valid_o SHALL equal (count_o != 0), except as modified by REQ-026.
REQ-016 data_o SHALL equal the entry at the head pointer; data written by a push SHALL appear on data_o at the earliest one cycle later (latency 1).
REQ-017 On push, data_i SHALL be written at the tail pointer, and the tail SHALL advance modulo DEPTH (DEPTH-1 wraps to 0).
REQ-018 On pop, the head SHALL advance modulo DEPTH, and no storage write SHALL occur.
REQ-019 count_o SHALL be +1 on push only, -1 on pop only, and unchanged on simultaneous push and pop.
REQ-020 When full, valid_i SHALL be ignored (ready_o=0), and a same-cycle pop SHALL still complete; no entry is ever overwritten.
REQ-021 When empty (without bypass), ready_i SHALL be ignored, and count_o SHALL never underflow.
REQ-022 flush_i SHALL take priority over push and pop: head, tail and count return to 0 on the next edge, and storage contents are left unchanged.
REQ-023 An in-flight valid_i/ready_o handshake coinciding with flush_i SHALL be dropped.

Reset
REQ-024 On rst_n_i low, head=0, tail=0 and count_o=0 SHALL apply immediately, giving ready_o=1 and valid_o=0; storage SHALL reset to '0, so data_o='0.
REQ-025 Reset asserted mid-transfer SHALL discard all contents, and no partial state SHALL survive deassertion.

Configuration
REQ-026 When macro FIFO_HS_BYPASS_EN is defined and count_o==0, the following SHALL apply:
- valid_o=valid_i and data_o=data_i combinationally.
- If ready_i is also high, the element passes through with zero latency, with no write and count_o unchanged.
- If ready_i is low, a normal push occurs.
REQ-027 When FIFO_HS_BYPASS_EN is undefined, there SHALL be no combinational path from valid_i/data_i to valid_o/data_o, and REQ-015/REQ-021 apply unchanged.

Structure
REQ-028 DATA_T SHALL be supplied by the instantiating unit from the shared core package, and the block SHALL define no package types of its own.
REQ-029 The head and tail pointers SHALL each be an instance of the existing modn_counter sub-module (N=DEPTH, en=push/pop, clr=flush_i).
REQ-030 The occupancy counter and storage array SHALL be local to fifo_hs.
REQ-031 Non-synthesis assertions SHALL check:
- count_o <= DEPTH.
- No push when full.
- No pop when empty (pop is legal in bypass).

Verification
REQ-032 Fill test: DEPTH=4, 8-bit data, push 0x11,0x22,0x33,0x44 with ready_i=0 -> count_o 1..4, ready_o=0 after the 4th, and a 5th push of 0x55 is not accepted.
REQ-033 Drain test: from full, ready_i=1 for 4 cycles -> data_o 0x11,0x22,0x33,0x44 in order, then valid_o=0 and count_o=0.
REQ-034 Simultaneous test: at count_o=2, push 0xAA with a pop in the same cycle -> count_o stays 2, and 0xAA is emerging after the older entries.
REQ-035 Wrap test: 10 continuous push/pop cycles with values 0..9 -> output order 0..9 with no loss across pointer wrap.
REQ-036 Flush test: at count_o=3, assert flush_i together with valid_i=1 -> next cycle count_o=0, valid_o=0, and the pushed element is discarded.
REQ-037 Bypass test (FIFO_HS_BYPASS_EN defined): empty FIFO with valid_i=1, data_i=0x5A, ready_i=1 -> same-cycle valid_o=1, data_o=0x5A, and count_o stays 0; without the macro -> valid_o=0 in that cycle and 0x5A appears next cycle.
